// File: rtl/pf_pkg.sv
// Shared playfield vertical-scroll definitions.
// Default widths and the scroll value type.
package pf_pkg;

  localparam int SCROLL_W = 9;
  localparam int FINE_W   = 3;

  typedef logic [SCROLL_W-1:0] vscroll_t;

endpackage

// File: rtl/pf_vscroll_cnt.sv
// Loadable, enabled, wrapping line counter.
// Emits a registered pulse when the fine field carries.
module pf_vscroll_cnt
  import pf_pkg::*;
#(
  parameter int SCROLL_W = pf_pkg::SCROLL_W,
  parameter int FINE_W   = pf_pkg::FINE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SCROLL_W-1:0] load_val,
  input  logic                inc,
  output logic [SCROLL_W-1:0] cnt,
  output logic                carry
);

  localparam logic [SCROLL_W-1:0] ONE = SCROLL_W'(1);

  logic [SCROLL_W-1:0] cnt_d, cnt_q;
  logic                tick_d, tick_q;

  // Load beats increment; carry only on an increment out of fine = max.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d  = cnt_q + ONE;
      tick_d = &cnt_q[FINE_W-1:0];
    end
  end

  // Counter and carry-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign cnt   = cnt_q;
  assign carry = tick_q;

endmodule

// File: rtl/pf_vscroll.sv
// Playfield vertical scroll: CPU shadow register
// applied at frame start, line counter per scanline.
module pf_vscroll
  import pf_pkg::*;
#(
  parameter int SCROLL_W = pf_pkg::SCROLL_W,
  parameter int FINE_W   = pf_pkg::FINE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scroll_we,
  input  logic [SCROLL_W-1:0]        scroll_data,
  input  logic                       vblank_end,
  input  logic                       hline_end,
  output logic [SCROLL_W-FINE_W-1:0] pf_row,
  output logic [FINE_W-1:0]          pf_fine,
  output logic                       row_tick,
  output logic                       scroll_pending
);

  logic [SCROLL_W-1:0] shadow_d, shadow_q;
  logic                pend_d, pend_q;
  logic [SCROLL_W-1:0] load_val;
  logic [SCROLL_W-1:0] cnt;

  // Shadow capture and pending flag; a write landing on
  // vblank_end bypasses the shadow and is applied at once.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (scroll_we) shadow_d = scroll_data;
    if (vblank_end) pend_d = 1'b0;
    else if (scroll_we) pend_d = 1'b1;
    load_val = scroll_we ? scroll_data : shadow_q;
  end

  // Shadow and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  pf_vscroll_cnt #(
    .SCROLL_W (SCROLL_W),
    .FINE_W   (FINE_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (vblank_end),
    .load_val (load_val),
    .inc      (hline_end),
    .cnt      (cnt),
    .carry    (row_tick)
  );

  assign pf_row         = cnt[SCROLL_W-1:FINE_W];
  assign pf_fine        = cnt[FINE_W-1:0];
  assign scroll_pending = pend_q;

endmodule

// File: tb/tb_pf_vscroll.sv
// Bench for pf_vscroll: directed scenarios plus
// random traffic against a frame-level reference model.
module tb_pf_vscroll;
  import pf_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scroll_we = 1'b0;
  vscroll_t   scroll_data = '0;
  logic       vblank_end = 1'b0;
  logic       hline_end = 1'b0;
  logic [5:0] pf_row;
  logic [2:0] pf_fine;
  logic       row_tick;
  logic       scroll_pending;

  int errors = 0;
  int checks = 0;

  int m_cnt  = 0;
  int m_sh   = 0;
  bit m_pend = 0;
  bit m_tick = 0;

  always #5 clk = ~clk;

  pf_vscroll dut (
    .clk            (clk),
    .reset          (reset),
    .scroll_we      (scroll_we),
    .scroll_data    (scroll_data),
    .vblank_end     (vblank_end),
    .hline_end      (hline_end),
    .pf_row         (pf_row),
    .pf_fine        (pf_fine),
    .row_tick       (row_tick),
    .scroll_pending (scroll_pending)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs, clock it, advance the model.
  task automatic step(input bit rst, input bit we,
                      input int d, input bit vb, input bit hl);
    reset       = rst;
    scroll_we   = we;
    scroll_data = vscroll_t'(d);
    vblank_end  = vb;
    hline_end   = hl;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_sh = 0; m_pend = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (vb) begin
        m_cnt  = we ? (d % 512) : m_sh;
        m_pend = 0;
      end else begin
        if (hl) begin
          m_cnt  = (m_cnt + 1) % 512;
          m_tick = (m_cnt % 8) == 0;
        end
        if (we) m_pend = 1;
      end
      if (we) m_sh = d % 512;
    end
    reset = 0; scroll_we = 0; scroll_data = '0;
    vblank_end = 0; hline_end = 0;
  endtask

  task automatic test_reset;
    step(1, 1, 'h1AB, 1, 1);
    checks++;
    if ({pf_row, pf_fine, row_tick, scroll_pending} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got row=%h fine=%h tick=%b pend=%b want 0",
               pf_row, pf_fine, row_tick, scroll_pending);
    end
  endtask

  task automatic test_fine_walk;
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (pf_fine !== 3'(k % 8) || pf_row !== ((k == 8) ? 6'd1 : 6'd0)
          || row_tick !== (k == 8)) begin
        errors++;
        $display("FAIL fine_walk[%0d]: got row=%h fine=%h tick=%b", k,
                 pf_row, pf_fine, row_tick);
      end
    end
  endtask

  task automatic test_wrap;
    int exp_c[3] = '{'h1FF, 'h000, 'h001};
    bit exp_t[3] = '{0, 1, 0};
    step(0, 1, 'h1FE, 0, 0);
    checks++;
    if (scroll_pending !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pend_set: got %b want 1", scroll_pending);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({pf_row, pf_fine} !== 9'h1FE || scroll_pending !== 1'b0
        || row_tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load: got cnt=%h pend=%b tick=%b want 1fe 0 0",
               {pf_row, pf_fine}, scroll_pending, row_tick);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if ({pf_row, pf_fine} !== 9'(exp_c[i]) || row_tick !== exp_t[i]) begin
        errors++;
        $display("FAIL wrap_inc[%0d]: got cnt=%h tick=%b want %h %b", i,
                 {pf_row, pf_fine}, row_tick, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_midframe;
    step(0, 1, 'h013, 1, 0);
    step(0, 1, 'h040, 0, 0);
    checks++;
    if ({pf_row, pf_fine} !== 9'h013 || scroll_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_write: got cnt=%h pend=%b want 013 1",
               {pf_row, pf_fine}, scroll_pending);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({pf_row, pf_fine} !== 9'h014 || scroll_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_inc: got cnt=%h pend=%b want 014 1",
               {pf_row, pf_fine}, scroll_pending);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({pf_row, pf_fine} !== 9'h040 || scroll_pending !== 1'b0) begin
      errors++;
      $display("FAIL mid_apply: got cnt=%h pend=%b want 040 0",
               {pf_row, pf_fine}, scroll_pending);
    end
  endtask

  task automatic test_coincident;
    step(0, 1, 'h007, 1, 0);
    step(0, 1, 'h155, 0, 0);
    step(0, 1, 'h0A7, 1, 1);
    checks++;
    if ({pf_row, pf_fine} !== 9'h0A7 || row_tick !== 1'b0
        || scroll_pending !== 1'b0) begin
      errors++;
      $display("FAIL coincident: got cnt=%h tick=%b pend=%b want 0a7 0 0",
               {pf_row, pf_fine}, row_tick, scroll_pending);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({pf_row, pf_fine} !== 9'h0A7) begin
      errors++;
      $display("FAIL coincident_shadow: got cnt=%h want 0a7",
               {pf_row, pf_fine});
    end
  endtask

  task automatic test_reset_midframe;
    step(0, 1, 'h155, 1, 0);
    step(0, 1, 'h0AA, 0, 0);
    step(1, 1, 'h1F0, 1, 1);
    checks++;
    if ({pf_row, pf_fine, row_tick, scroll_pending} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%h tick=%b pend=%b want 0",
               {pf_row, pf_fine}, row_tick, scroll_pending);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if ({pf_row, pf_fine} !== 9'h000 || scroll_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_reload: got cnt=%h pend=%b want 000 0",
               {pf_row, pf_fine}, scroll_pending);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 511)), $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0);
      checks++;
      if ({pf_row, pf_fine} !== 9'(m_cnt) || row_tick !== m_tick
          || scroll_pending !== m_pend) begin
        errors++;
        $display("FAIL random[%0d]: got cnt=%h tick=%b pend=%b want %h %b %b",
                 i, {pf_row, pf_fine}, row_tick, scroll_pending,
                 9'(m_cnt), m_tick, m_pend);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fine_walk;
    test_wrap;
    test_midframe;
    test_coincident;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pf_vscroll.md
PF_VSCROLL -- requirements
Module: pf_vscroll

Interface
REQ-001 Parameter: SCROLL_W, 9, width of vertical scroll value and line counter (512-line playfield).
REQ-002 Parameter: FINE_W, 3, low counter bits selecting pixel row within an 8-line tile.
REQ-003 Port: clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  reset is synchronous and active-high.
REQ-005 Port: scroll_we  input  1  CPU write strobe for vertical scroll register.
REQ-006 Port: scroll_data  input  SCROLL_W  CPU-written vertical scroll value.
REQ-007 Port: vblank_end  input  1  one-cycle pulse at start of first visible scanline.
REQ-008 Port: hline_end  input  1  one-cycle pulse at end of each scanline.
REQ-009 Port: pf_row  output  SCROLL_W-FINE_W  playfield tile-row address (counter upper bits).
REQ-010 Port: pf_fine  output  FINE_W  pixel row within tile (counter lower bits).
REQ-011 Port: row_tick  output  1  one-cycle pulse when pf_row advances (fine carry).
REQ-012 Port: scroll_pending  output  1  written scroll value not yet applied to display.

Function
REQ-013 scroll_we SHALL load shadow register with scroll_data on the same clock edge; shadow visible to counter one cycle later.
REQ-014 scroll_pending SHALL go high the cycle after scroll_we and SHALL clear the cycle after the next vblank_end.
REQ-015 vblank_end SHALL load line counter with shadow value; if scroll_we coincides, scroll_data SHALL be loaded directly and scroll_pending SHALL end low.
REQ-016 hline_end (without vblank_end) SHALL increment line counter by 1 modulo 2^SCROLL_W (511 -> 0 wrap, no flag).
REQ-017 vblank_end and hline_end coincident: load SHALL win, no increment that cycle.
REQ-018 Counter SHALL never change mid-frame on scroll_we; writes affect display only at next vblank_end (no tearing).
REQ-019 {pf_row, pf_fine} SHALL be the counter register directly; latency 1 cycle from load/increment event.
REQ-020 row_tick SHALL be a registered pulse, high exactly one cycle, coincident with the counter update where increment carries fine from 7 to 0 (includes 511 -> 0).
REQ-021 row_tick SHALL NOT assert on a load, even if loaded value has fine = 0.
REQ-022 Outputs SHALL hold value when neither vblank_end nor hline_end asserted.

Reset
REQ-023 reset SHALL take priority over all inputs on the same edge.
REQ-024 On reset: counter = 0, shadow = 0, pf_row = 0, pf_fine = 0, row_tick = 0, scroll_pending = 0.
REQ-025 Reset mid-frame SHALL discard shadow and pending write; next vblank_end loads 0.

Structure
REQ-026 Shared package pf_pkg SHALL hold SCROLL_W, FINE_W defaults and typedef vscroll_t (SCROLL_W-bit logic).
REQ-027 One sub-module pf_vscroll_cnt SHALL implement the loadable, enabled, wrapping counter with fine-carry output; shadow/pending logic stays in pf_vscroll.

Verification
REQ-028 Reset, then 8 hline_end pulses -> pf_fine 0..7 then 0, pf_row 0 -> 1, single row_tick on 8th pulse.
REQ-029 scroll_we data 0x1FE, vblank_end, 3 hline_end -> counter 0x1FE, 0x1FF, 0x000, 0x001; row_tick on 0x1FF -> 0x000 only; scroll_pending cleared after vblank_end.
REQ-030 scroll_we data 0x040 mid-frame at counter 0x013 -> counter continues 0x014 on next hline_end; scroll_pending high until vblank_end, then counter = 0x040.
REQ-031 vblank_end, hline_end and scroll_we (data 0x0A7) same cycle -> counter = 0x0A7, no row_tick, scroll_pending low.
REQ-032 reset asserted with scroll_pending high and counter 0x155 -> all outputs 0 next cycle; following vblank_end loads 0x000.
